// File: rtl/m1_pkg.sv
// rtl/m1_pkg.sv - shared widths and state encoding for the m1 byte cipher
package m1_pkg;

    localparam int M1_BYTE_W = 8;
    localparam int M1_IDX_W  = $clog2(M1_BYTE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_HOLD  = 2'd3
    } m1_state_t;

endpackage

// File: rtl/m1_parity.sv
// rtl/m1_parity.sv - byte parity generator, odd or even selected by PAR_ODD
module m1_parity
    import m1_pkg::*;
#(
    parameter bit PAR_ODD = 1'b1
) (
    input  logic [M1_BYTE_W-1:0] data,
    output logic                 par
);

    // Odd parity inverts the XOR so byte plus parity bit carries an odd count of ones
    assign par = (^data) ^ PAR_ODD;

endmodule

// File: rtl/m1_byte_cipher.sv
// rtl/m1_byte_cipher.sv - bit-serial byte cipher front end; M1_PARITY_EN adds the parity state
module m1_byte_cipher
    import m1_pkg::*;
#(
    parameter bit PAR_ODD = 1'b1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M1_BYTE_W-1:0] in_data,
    input  logic                 in_mode,
    input  logic                 in_feed,
    input  logic                 in_par,
    input  logic                 ks_in,
    output logic                 ks_shift,
    output logic                 ser_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M1_BYTE_W-1:0] out_data,
    output logic                 out_par,
    output logic                 out_par_err,
    output logic                 busy
);

    localparam logic [M1_IDX_W-1:0] IDX_LAST = M1_IDX_W'(M1_BYTE_W - 1);

    m1_state_t             state;
    logic [M1_IDX_W-1:0]   idx;
    logic [M1_BYTE_W-1:0]  data_q;
    logic                  mode_q;
    logic                  feed_q;
    logic                  par_q;
    logic [M1_BYTE_W-1:0]  plain;
    logic                  par_bit;

    // Plaintext is the input byte when encrypting and the recovered byte when decrypting
    assign plain = mode_q ? out_data : data_q;

    m1_parity #(
        .PAR_ODD (PAR_ODD)
    ) u_parity (
        .data (plain),
        .par  (par_bit)
    );

    assign in_ready  = (state == ST_IDLE) && !clear && !reset;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    // Clear kills the core advance in the same cycle, not one edge later
    assign ks_shift  = (state == ST_SHIFT) && !clear;

    // Plaintext bit i goes to the core when feeding; decrypt recovers it from the keystream first
    always_comb begin
        ser_out = 1'b0;
        if ((state == ST_SHIFT) && feed_q) begin
            ser_out = mode_q ? (data_q[idx] ^ ks_in) : data_q[idx];
        end
    end

    // Main sequencer: accept, shift eight bits LSB first, optional parity, hold for the sink
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            feed_q   <= 1'b0;
            par_q    <= 1'b0;
            out_data <= '0;
        end else if (clear) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mode_q <= in_mode;
                        feed_q <= in_feed;
                        par_q  <= in_par;
                        idx    <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    out_data[idx] <= data_q[idx] ^ ks_in;
                    if (idx == IDX_LAST) begin
                        idx <= '0;
`ifdef M1_PARITY_EN
                        state <= ST_PAR;
`else
                        state <= ST_HOLD;
`endif
                    end else begin
                        idx <= idx + M1_IDX_W'(1);
                    end
                end
`ifdef M1_PARITY_EN
                ST_PAR: begin
                    state <= ST_HOLD;
                end
`endif
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef M1_PARITY_EN
    logic out_par_q;
    logic out_par_err_q;

    // Parity uses the keystream bit without shifting; that bit is reused by the next byte's bit 0
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            out_par_q     <= 1'b0;
            out_par_err_q <= 1'b0;
        end else if (!clear && (state == ST_PAR)) begin
            if (mode_q) begin
                out_par_q     <= par_q ^ ks_in;
                out_par_err_q <= (par_q ^ ks_in) != par_bit;
            end else begin
                out_par_q     <= par_bit ^ ks_in;
                out_par_err_q <= 1'b0;
            end
        end
    end

    assign out_par     = out_par_q;
    assign out_par_err = out_par_err_q;
`else
    logic unused_par;

    // Without the parity state the parity path has no consumer
    assign unused_par  = ^{par_q, par_bit};
    assign out_par     = 1'b0;
    assign out_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_m1_byte_cipher.sv
// tb/tb_m1_byte_cipher.sv - randomized self-checking bench for m1_byte_cipher
module tb_m1_byte_cipher;

`ifdef M1_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LAT    = 10;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LAT    = 9;
`endif
    localparam bit PAR_ODD_TB = 1'b1;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_mode = 1'b0;
    logic       in_feed = 1'b0;
    logic       in_par = 1'b0;
    logic       ks_in = 1'b0;
    logic       ks_shift;
    logic       ser_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_par;
    logic       out_par_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int n_shift;
    int n_wait;

    m1_byte_cipher #(
        .PAR_ODD (PAR_ODD_TB)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .in_feed     (in_feed),
        .in_par      (in_par),
        .ks_in       (ks_in),
        .ks_shift    (ks_shift),
        .ser_out     (ser_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_par     (out_par),
        .out_par_err (out_par_err),
        .busy        (busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Parity bit that makes the byte plus bit odd (PAR_ODD) or even in ones count
    function automatic logic par_of(input logic [7:0] b);
        par_of = (($countones(b) % 2) == 0) ? PAR_ODD_TB : !PAR_ODD_TB;
    endfunction

    task automatic run_byte(input logic [7:0] d, input logic m, input logic f, input logic p,
                            input logic [8:0] ks, input int stall);
        logic [7:0] plain, exp_data, ser_bits, snap;
        logic       exp_par, exp_err, ser_extra, rdy_seen, idle_seen, stall_bad;
        int         shifts, vcyc;
        exp_data = d ^ ks[7:0];
        plain    = m ? exp_data : d;
        if (PAR_EN) begin
            exp_par = m ? (p ^ ks[8]) : (par_of(d) ^ ks[8]);
            exp_err = m ? (exp_par != par_of(plain)) : 1'b0;
        end else begin
            exp_par = 1'b0;
            exp_err = 1'b0;
        end
        @(posedge sysclk); #1;
        in_valid = 1'b1; in_data = d; in_mode = m; in_feed = f; in_par = p;
        out_ready = 1'b0; ks_in = 1'($urandom_range(0, 1));
        @(negedge sysclk);
        check("accept_ready", 32'(in_ready), 32'd1);
        shifts = 0; ser_bits = 8'h00; ser_extra = 1'b0; rdy_seen = 1'b0; idle_seen = 1'b0; vcyc = 0;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge sysclk); #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_mode  = 1'($urandom_range(0, 1));
            in_feed  = 1'($urandom_range(0, 1));
            in_par   = 1'($urandom_range(0, 1));
            ks_in    = (c <= 9) ? ks[c-1] : 1'b0;
            @(negedge sysclk);
            if (ks_shift) shifts++;
            if (c <= 8) ser_bits[c-1] = ser_out;
            else if (ser_out) ser_extra = 1'b1;
            if (in_ready) rdy_seen = 1'b1;
            if (!busy) idle_seen = 1'b1;
            if (out_valid) begin
                vcyc = c;
                break;
            end
        end
        check("latency", 32'(vcyc), 32'(LAT));
        check("ks_shift_count", 32'(shifts), 32'd8);
        check("ser_bits", 32'(ser_bits), f ? 32'(plain) : 32'd0);
        check("ser_idle_zero", 32'(ser_extra), 32'd0);
        check("ready_while_busy", 32'(rdy_seen), 32'd0);
        check("busy_gap", 32'(idle_seen), 32'd0);
        check("out_data", 32'(out_data), 32'(exp_data));
        check("out_par", 32'(out_par), 32'(exp_par));
        check("out_par_err", 32'(out_par_err), 32'(exp_err));
        snap = out_data;
        stall_bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge sysclk); #1;
            @(negedge sysclk);
            if (out_data !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
        end
        if (stall > 0) check("hold_stable", 32'(stall_bad), 32'd0);
        @(posedge sysclk); #1; out_ready = 1'b1;
        @(posedge sysclk); #1; out_ready = 1'b0;
        @(negedge sysclk);
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge sysclk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ks_shift", 32'(ks_shift), 32'd0);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_par", 32'(out_par), 32'd0);
        check("rst_out_par_err", 32'(out_par_err), 32'd0);
        @(posedge sysclk); #1; reset = 1'b0;
        @(negedge sysclk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        run_byte(8'h00, 1'b0, 1'b0, 1'b0, 9'h1FF, 0);
        run_byte(8'hFF, 1'b1, 1'b0, 1'b0, 9'h1FF, 0);
        run_byte(8'hFF, 1'b1, 1'b0, 1'b1, 9'h1FF, 0);
        run_byte(8'hA5, 1'b0, 1'b1, 1'b0, 9'h000, 0);
        run_byte(8'h3C, 1'b0, 1'b1, 1'b0, 9'($urandom), 5);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            run_byte(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 9'($urandom), $urandom_range(0, 3));
        end

        // Reset in the middle of a byte at bit index 3
        @(posedge sysclk); #1;
        in_valid = 1'b1; in_data = 8'hFF; in_mode = 1'b0; in_feed = 1'b1; ks_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge sysclk); #1;
            in_valid = 1'b0;
        end
        @(negedge sysclk);
        check("mid_pre_shift", 32'(ks_shift), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ks_shift", 32'(ks_shift), 32'd0);
        check("mid_rst_ser_out", 32'(ser_out), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_par", 32'(out_par), 32'd0);
        check("mid_rst_par_err", 32'(out_par_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        n_shift = 0;
        repeat (2) begin
            @(negedge sysclk);
            if (ks_shift) n_shift++;
        end
        check("mid_rst_no_pulse", 32'(n_shift), 32'd0);
        @(posedge sysclk); #1; reset = 1'b0;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        check("mid_rel_ks_shift", 32'(ks_shift), 32'd0);

        // Clear during SHIFT
        @(posedge sysclk); #1;
        in_valid = 1'b1; in_data = 8'($urandom); in_feed = 1'b0;
        @(posedge sysclk); #1; in_valid = 1'b0;
        @(posedge sysclk); #1; clear = 1'b1;
        @(negedge sysclk);
        check("clr_shift_drop", 32'(ks_shift), 32'd0);
        check("clr_shift_busy", 32'(busy), 32'd1);
        @(posedge sysclk); #1; clear = 1'b0;
        @(negedge sysclk);
        check("clr_shift_idle", 32'(busy), 32'd0);
        check("clr_shift_no_pulse", 32'(ks_shift), 32'd0);

        // Clear during HOLD discards the byte without a handshake
        @(posedge sysclk); #1;
        in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b0;
        @(posedge sysclk); #1; in_valid = 1'b0;
        n_wait = 0;
        while (!out_valid && n_wait < 20) begin
            @(negedge sysclk);
            n_wait++;
        end
        check("clr_hold_reached", 32'(out_valid), 32'd1);
        @(posedge sysclk); #1; clear = 1'b1;
        @(negedge sysclk);
        check("clr_hold_ready", 32'(in_ready), 32'd0);
        @(posedge sysclk); #1; clear = 1'b0;
        @(negedge sysclk);
        check("clr_hold_valid", 32'(out_valid), 32'd0);
        check("clr_hold_idle", 32'(busy), 32'd0);

        // Clear in IDLE wins over a pending request
        @(posedge sysclk); #1; clear = 1'b1; in_valid = 1'b1;
        @(negedge sysclk);
        check("clr_idle_ready", 32'(in_ready), 32'd0);
        @(posedge sysclk); #1; clear = 1'b0; in_valid = 1'b0;
        @(negedge sysclk);
        check("clr_idle_no_accept", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
